// File: rtl/bcd_countdown_timer_if.sv
// Bundle of control inputs and status outputs for the BCD countdown timer.
// Pure wiring: no logic and no added latency.
// No backpressure: the timer samples its controls every cycle.
interface bcd_countdown_timer_if #(
    parameter int DIGITS = 2
);
    logic                  load;
    logic [4*DIGITS-1:0]   load_bcd;
    logic                  start;
    logic                  tick;
    logic [4*DIGITS-1:0]   count;
    logic                  busy;
    logic                  done;
    logic                  invalid;

    // Controller side: drives the controls, observes the status.
    modport master (
        output load,
        output load_bcd,
        output start,
        output tick,
        input  count,
        input  busy,
        input  done,
        input  invalid
    );

    // Timer side: observes the controls, drives the status.
    modport slave (
        input  load,
        input  load_bcd,
        input  start,
        input  tick,
        output count,
        output busy,
        output done,
        output invalid
    );
endinterface

// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD down-counter with load/start; done pulses when a run reaches zero.
// Latency: all outputs registered, one cycle after the qualifying edge.
// No backpressure: controls are sampled every cycle (load > start > tick priority).
module bcd_countdown_timer #(
    parameter int DIGITS = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    bcd_countdown_timer_if.slave        bus
);

    localparam int W = 4 * DIGITS;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [W-1:0]   count_q;
    logic [W-1:0]   count_d;
    logic           invalid_q;
    logic           invalid_d;

    // True when every 4-bit digit of v is in the range 0..9.
    function automatic logic is_bcd(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

    // BCD subtract-one with borrow ripple; zero is returned unchanged so the
    // count can never wrap to all nines.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = (v != '0);
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    logic count_is_zero;
    logic count_is_one;
    logic load_ok;

    assign count_is_zero = (count_q == '0);
    assign count_is_one  = (count_q == W'(1));
    assign load_ok       = is_bcd(bus.load_bcd);

    // Next-state, next-count and invalid-flag decode with load taking priority.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        invalid_d = 1'b0;

        if (bus.load) begin
            // A load swallows any same-cycle start or tick.
            if (load_ok) begin
                count_d = bus.load_bcd;
                state_d = ST_IDLE;
            end else begin
                invalid_d = 1'b1;
            end
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_d = count_is_zero ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.tick) begin
                        if (count_is_one || count_is_zero) begin
                            // Final decrement; zero case is unreachable but
                            // finishes cleanly rather than stalling in RUN.
                            count_d = '0;
                            state_d = ST_DONE;
                        end else begin
                            count_d = bcd_dec(count_q);
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, count and invalid registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            invalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            invalid_q <= invalid_d;
        end
    end

    // Moore outputs decoded straight from the registered state.
    assign bus.count   = count_q;
    assign bus.busy    = (state_q == ST_RUN);
    assign bus.done    = (state_q == ST_DONE);
    assign bus.invalid = invalid_q;

endmodule

// File: doc/bcd_countdown_timer.md
# bcd_countdown_timer

Multi-digit BCD down-counter with load, start and completion handshake. It is the count-down companion to the decade up-counter. It consumes a one-cycle `tick` qualifier, typically the decade counter's `ten` pulse or any enable strobe, and decrements a loaded BCD value to zero. On reaching zero it issues a one-cycle `done` pulse. It sits in the timing datapath wherever a programmable delay or timeout is needed.

## Interface
- `DIGITS`, default 2: number of BCD digits; the count width is 4*DIGITS.

- `clk`  in  1: single clock; all state updates on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `load`  in  1: capture `load_bcd` into the count and abort any run.
- `load_bcd`  in  4*DIGITS: BCD preset value, least significant digit in bits [3:0].
- `start`  in  1: begin counting down from the current count.
- `tick`  in  1: decrement qualifier; one decrement per cycle in which it is high during RUN.
- `count`  out  4*DIGITS: current BCD count, registered.
- `busy`  out  1: high while in state RUN.
- `done`  out  1: one-cycle completion pulse.
- `invalid`  out  1: one-cycle pulse flagging a rejected load (a non-BCD digit).

## Operation
- States are IDLE, RUN and DONE; the reset state is IDLE.
- Reset values: `count`=0, `busy`=0, `done`=0, `invalid`=0.
- Input priority per cycle: `reset` > `load` > `start` > `tick`.
- `load` behaviour, in any state:
  - If every digit of `load_bcd` is ≤ 9: count ← `load_bcd` and the next state is IDLE. A run in progress is aborted with no `done`.
  - If any digit is > 9: count is unchanged, the state is unchanged, and `invalid` = 1 for the next cycle only.
  - A same-cycle `start` or `tick` is ignored.
- IDLE transitions:
  - `start` with count ≠ 0 → RUN.
  - `start` with count = 0 → DONE.
  - `tick` alone is ignored.
- RUN behaviour:
  - `tick` with count ≠ 1 (BCD value) decrements the count and stays in RUN.
  - `tick` with count = 1 sets count ← 0 and moves to DONE.
  - `start` is ignored.
  - Without `tick`, the count holds.
- DONE behaviour: unconditionally → IDLE next cycle, unless `load` or `reset` applies.
- BCD decrement rules:
  - Digit 0 becomes 9 and borrows from the next digit; any other digit decrements by 1.
  - All-zero is never decremented; it never underflows to 99…9.
- Output decode:
  - `busy` = (state == RUN).
  - `done` = (state == DONE).
  - Both are Moore outputs, registered via the state.
- Once loaded, `count` holds its value across DONE/IDLE. A second `start` with count = 0 produces an immediate DONE.

## Timing
- `load` at edge N: `count` shows the new value in cycle N+1.
- `start` at edge N:
  - `busy` is high from cycle N+1.
  - With count = 0, `done` is high in cycle N+1 instead.
- `tick` at edge N in RUN: the decremented `count` is visible in cycle N+1.
- Final tick at edge N:
  - In cycle N+1: `count` = 0, `done` = 1, `busy` = 0.
  - In cycle N+2: `done` = 0.
- `done` is exactly one cycle wide. Back-to-back runs are possible: a `start` during the DONE cycle is ignored, and a `start` in the following IDLE cycle is accepted.
- Latency from `start` to `done` is K+1 cycles minimum for a loaded value K, when `tick` is held high.
- `tick` gaps of any length stall the count with no state change.
- Reset mid-run: at the next edge all outputs return to their reset values, with no `done` pulse.

## Test plan
- Load `0x12` (DIGITS=2), start, then `tick` held high: `count` follows 12,11,10,09,…,01,00. `done` pulses once, coincident with 00. `busy` is high for exactly 12 cycles.
- Borrow chain with DIGITS=3: load `0x100`, start, one tick → `count` = `0x099`. Load `0x010`, start, one tick → `0x009`.
- Non-BCD load of `0x1A`:
  - In the next cycle `invalid` = 1 for one cycle and `count` is unchanged (previous `0x12`).
  - In the following cycle `invalid` = 0.
- Load `0x00`, then start: `done` = 1 in the next cycle, `busy` never asserts. Issuing start again → another single `done` pulse.
- Abort scenarios:
  - Load `0x05`, start, two ticks (`count` = `0x03`), then load `0x07` with a same-cycle tick → `count` = `0x07`, state IDLE, no `done`.
  - Repeat the run, then assert `reset` at `count` = `0x02` → `count` = 0 with `busy`/`done` low, and no `done` pulse.
- Sparse ticks: load `0x03`, start, ticks on every 4th cycle → `count` changes only after tick cycles. `done` follows the 3rd tick by one cycle. `start` pulses during RUN have no effect.
